// File: rtl/ex7.sv
// Registered 15-input priority encoder. Reports 1 + the index of the highest
// asserted request line, or 0 when no line is asserted.
module ex7 #(
  localparam int N     = 15,
  localparam int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     t,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    out_d   = '0;
    valid_d = |t;
    // Ascending scan: the last hit overwrites earlier ones, so the highest index wins.
    for (int i = 0; i < N; i++) begin
      if (t[i]) begin
        out_d = OUT_W'(i + 1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_ex7.sv
// Self-checking bench for ex7: directed scenarios plus random vectors checked
// against an arithmetic model of the priority code.
module tb_ex7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] t = '0;
  logic [3:0]  out;
  logic        valid;

  int vectors     = 0;
  int miscompares = 0;

  ex7 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .t     (t),
    .out   (out),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Highest set bit index + 1 equals ceil(log2(v + 1)) for any unsigned v.
  function automatic logic [3:0] ref_code(input logic [14:0] v);
    return 4'($clog2(int'(v) + 1));
  endfunction

  // Drive a new request vector mid-cycle, then sample just after the next edge.
  task automatic apply(input logic [14:0] v);
    @(negedge clk);
    t = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_o;
    rst_n = 1'b0;
    t     = 15'h7FFF;
    #2;
    vectors++;
    if (out !== 4'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: out=%0d valid=%0b, expected out=0 valid=0", out, valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(15'h7FFF);
    exp_o = ref_code(15'h7FFF);
    vectors++;
    if (out !== exp_o || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_load: out=%0d valid=%0b, expected out=%0d valid=1", out, valid, exp_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out !== 4'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: out=%0d valid=%0b, expected out=0 valid=0", out, valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 4'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held_over_edge: out=%0d valid=%0b, expected out=0 valid=0", out, valid);
    end
    @(negedge clk);
    t     = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 4'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: out=%0d valid=%0b, expected out=0 valid=0", out, valid);
    end
  endtask

  task automatic test_single_bits();
    for (int i = 0; i < 15; i++) begin
      apply(15'(1) << i);
      vectors++;
      if (out !== 4'(i + 1) || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL single_bit[%0d]: out=%0d valid=%0b, expected out=%0d valid=1", i, out, valid, i + 1);
      end
    end
  endtask

  int order [15] = '{0, 5, 1, 3, 2, 6, 4, 14, 8, 7, 12, 10, 11, 9, 13};

  task automatic test_scrambled_accum();
    logic [14:0] v = '0;
    apply(v);
    for (int s = 0; s < 15; s++) begin
      v[order[s]] = 1'b1;
      apply(v);
      for (int h = 0; h < 3; h++) begin
        vectors++;
        if (out !== ref_code(v) || valid !== 1'b1) begin
          miscompares++;
          $display("FAIL accum_step%0d_bit%0d: out=%0d valid=%0b, expected out=%0d valid=1",
                   s, order[s], out, valid, ref_code(v));
        end
        if (h < 2) apply(v);
      end
    end
    vectors++;
    if (out !== 4'd15) begin
      miscompares++;
      $display("FAIL accum_all_set: out=%0d, expected 15", out);
    end
  endtask

  task automatic test_scrambled_release();
    logic [14:0] v = 15'h7FFF;
    apply(v);
    for (int s = 0; s < 15; s++) begin
      v[order[s]] = 1'b0;
      apply(v);
      apply(v);
      vectors++;
      if (out !== ref_code(v) || valid !== (v != 0)) begin
        miscompares++;
        $display("FAIL release_step%0d_bit%0d: out=%0d valid=%0b, expected out=%0d valid=%0b",
                 s, order[s], out, valid, ref_code(v), v != 0);
      end
    end
    vectors++;
    if (out !== 4'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release_all_clear: out=%0d valid=%0b, expected out=0 valid=0", out, valid);
    end
  endtask

  task automatic test_latency();
    logic [14:0] prev = 15'h0001;
    logic [14:0] cur;
    apply(prev);
    for (int c = 0; c < 12; c++) begin
      cur = (c % 2 == 0) ? 15'h4000 : 15'h0001;
      @(negedge clk);
      t = cur;
      #1;
      vectors++;
      if (out !== ref_code(prev)) begin
        miscompares++;
        $display("FAIL latency_before_edge%0d: out=%0d, expected %0d", c, out, ref_code(prev));
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out !== ref_code(cur) || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL latency_after_edge%0d: out=%0d valid=%0b, expected out=%0d valid=1",
                 c, out, valid, ref_code(cur));
      end
      prev = cur;
    end
  endtask

  task automatic test_reset_mid_run();
    apply(15'h0100);
    vectors++;
    if (out !== 4'd9) begin
      miscompares++;
      $display("FAIL midrun_preload: out=%0d, expected 9", out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out !== 4'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_async_clear: out=%0d valid=%0b, expected out=0 valid=0", out, valid);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 4'd9 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_recover: out=%0d valid=%0b, expected out=9 valid=1", out, valid);
    end
  endtask

  task automatic test_random();
    logic [14:0] v;
    logic [14:0] glitch;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 15'($urandom);
        1:       v = (15'(1) << $urandom_range(0, 14)) | (15'($urandom) & 15'h00FF);
        2:       v = 15'($urandom) >> $urandom_range(0, 14);
        default: v = ($urandom_range(0, 7) == 0) ? 15'h0000 : 15'(1) << $urandom_range(0, 14);
      endcase
      glitch = 15'($urandom);
      @(negedge clk);
      t = glitch;
      #1;
      t = v;
      @(posedge clk);
      #1;
      vectors++;
      if (out !== ref_code(v) || valid !== (v != 0)) begin
        miscompares++;
        $display("FAIL random%0d t=%h: out=%0d valid=%0b, expected out=%0d valid=%0b",
                 n, v, out, valid, ref_code(v), v != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bits();
    test_scrambled_accum();
    test_scrambled_release();
    test_latency();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
